// File: rtl/bbox_pkg.sv
// Shared types, defaults and width helpers for the bounding-box stream tracker.
package bbox_pkg;

   localparam int unsigned DEF_WIDTH  = 100;
   localparam int unsigned DEF_HEIGHT = 100;
   localparam int unsigned DEF_NUM_CH = 3;
   localparam int unsigned DEF_THRESH = 250;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } bbox_state_t;

   // Width holding 0..max(w,h)-1, never narrower than one bit.
   function automatic int unsigned coord_width(input int unsigned w, input int unsigned h);
      int unsigned m;
      m = (w > h) ? w : h;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   // Width holding 0..n-1, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Component/column/row walker for a bottom-up raster scan; clear beats advance.
module raster_counter
   import bbox_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned HEIGHT = DEF_HEIGHT,
   parameter int unsigned NUM_CH = DEF_NUM_CH,
   localparam int unsigned CW    = coord_width(WIDTH, HEIGHT),
   localparam int unsigned CHW   = idx_width(NUM_CH)
) (
   input  logic           CLOCK_50,
   input  logic           reset_n,
   input  logic           clr,
   input  logic           adv,
   output logic [CHW-1:0] ch,
   output logic [CW-1:0]  x,
   output logic [CW-1:0]  y,
   output logic           last_ch_c,
   output logic           last_beat_c
);

   assign last_ch_c   = (ch == CHW'(NUM_CH - 1));
   assign last_beat_c = last_ch_c && (x == CW'(WIDTH - 1)) && (y == '0);

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n || clr) begin
         ch <= '0;
         x  <= '0;
         y  <= CW'(HEIGHT - 1);
      end else if (adv) begin
         if (last_ch_c) begin
            ch <= '0;
            if (x == CW'(WIDTH - 1)) begin
               x <= '0;
               y <= (y == '0) ? CW'(HEIGHT - 1) : y - CW'(1);
            end else begin
               x <= x + CW'(1);
            end
         end else begin
            ch <= ch + CHW'(1);
         end
      end
   end

endmodule

// File: rtl/bbox_stream_tracker.sv
// Streams pixel components, tracks the foreground bounding box and count,
// and publishes a held result with a one-cycle frame_done at end of frame.
module bbox_stream_tracker
   import bbox_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned HEIGHT = DEF_HEIGHT,
   parameter int unsigned NUM_CH = DEF_NUM_CH,
   parameter int unsigned DW     = 8,
   parameter int unsigned THRESH = DEF_THRESH,
   localparam int unsigned CW    = coord_width(WIDTH, HEIGHT),
   localparam int unsigned NW    = $clog2(WIDTH * HEIGHT + 1),
   localparam int unsigned CHW   = idx_width(NUM_CH)
) (
   input  logic          CLOCK_50,
   input  logic          reset_n,
   input  logic          sof,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic [CW-1:0] x_min,
   output logic [CW-1:0] x_max,
   output logic [CW-1:0] y_min,
   output logic [CW-1:0] y_max,
   output logic          bbox_empty,
   output logic [NW-1:0] fg_count,
   output logic          frame_done,
   output logic          busy
);

   bbox_state_t    state;
   logic [CW-1:0]  acc_xmin, acc_xmax, acc_ymin, acc_ymax;
   logic [NW-1:0]  acc_cnt;
   logic           fg_flag;

   logic [CHW-1:0] ch;
   logic [CW-1:0]  x, y;
   logic           last_ch_c, last_beat_c;
   logic           adv_c, upd_c;
   logic [CW-1:0]  nxt_xmin_c, nxt_xmax_c, nxt_ymin_c, nxt_ymax_c;
   logic [NW-1:0]  nxt_cnt_c;

   // sof wins over a coincident beat, which is dropped.
   assign adv_c = in_valid && in_ready && !sof;

   raster_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .NUM_CH (NUM_CH)
   ) u_raster (
      .CLOCK_50    (CLOCK_50),
      .reset_n     (reset_n),
      .clr         (sof),
      .adv         (adv_c),
      .ch          (ch),
      .x           (x),
      .y           (y),
      .last_ch_c   (last_ch_c),
      .last_beat_c (last_beat_c)
   );

   // Accumulator values including the current beat, so the final pixel is published.
   always_comb begin
      upd_c      = adv_c && last_ch_c && (fg_flag || (32'(in_data) < THRESH));
      nxt_xmin_c = acc_xmin;
      nxt_xmax_c = acc_xmax;
      nxt_ymin_c = acc_ymin;
      nxt_ymax_c = acc_ymax;
      nxt_cnt_c  = acc_cnt;
      if (upd_c) begin
         if (x < acc_xmin) nxt_xmin_c = x;
         if (x > acc_xmax) nxt_xmax_c = x;
         if (y < acc_ymin) nxt_ymin_c = y;
         if (y > acc_ymax) nxt_ymax_c = y;
         nxt_cnt_c = acc_cnt + NW'(1);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         x_min      <= '0;
         x_max      <= '0;
         y_min      <= '0;
         y_max      <= '0;
         bbox_empty <= 1'b1;
         fg_count   <= '0;
         acc_xmin   <= CW'(WIDTH - 1);
         acc_xmax   <= '0;
         acc_ymin   <= CW'(HEIGHT - 1);
         acc_ymax   <= '0;
         acc_cnt    <= '0;
         fg_flag    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (sof) begin
            // Start or restart from any state; DONE has already published on entry.
            state    <= SCAN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            acc_xmin <= CW'(WIDTH - 1);
            acc_xmax <= '0;
            acc_ymin <= CW'(HEIGHT - 1);
            acc_ymax <= '0;
            acc_cnt  <= '0;
            fg_flag  <= 1'b0;
         end else begin
            case (state)
               SCAN: begin
                  if (adv_c) begin
                     acc_xmin <= nxt_xmin_c;
                     acc_xmax <= nxt_xmax_c;
                     acc_ymin <= nxt_ymin_c;
                     acc_ymax <= nxt_ymax_c;
                     acc_cnt  <= nxt_cnt_c;
                     fg_flag  <= last_ch_c ? 1'b0 : (fg_flag || (32'(in_data) < THRESH));
                     if (last_beat_c) begin
                        state      <= DONE;
                        in_ready   <= 1'b0;
                        frame_done <= 1'b1;
                        bbox_empty <= (nxt_cnt_c == '0);
                        fg_count   <= nxt_cnt_c;
                        x_min      <= (nxt_cnt_c == '0) ? '0 : nxt_xmin_c;
                        x_max      <= (nxt_cnt_c == '0) ? '0 : nxt_xmax_c;
                        y_min      <= (nxt_cnt_c == '0) ? '0 : nxt_ymin_c;
                        y_max      <= (nxt_cnt_c == '0) ? '0 : nxt_ymax_c;
                     end
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bbox_stream_tracker.sv
// Directed bench for bbox_stream_tracker on a 4x3, 3-component frame (36 beats).
module tb_bbox_stream_tracker;

   localparam int unsigned W = 4, H = 3, NC = 3, DWL = 8, TH = 250;
   localparam int unsigned NB = W * H * NC;

   logic       CLOCK_50 = 1'b0;
   logic       reset_n  = 1'b0;
   logic       sof      = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data  = 8'd0;
   logic [1:0] x_min, x_max, y_min, y_max;
   logic       bbox_empty;
   logic [3:0] fg_count;
   logic       frame_done, busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  frame [NB];
   logic [12:0] res;

   localparam logic [12:0] RES_EMPTY  = {2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0};
   localparam logic [12:0] RES_ONE    = {2'd2, 2'd2, 2'd1, 2'd1, 1'b0, 4'd1};
   localparam logic [12:0] RES_CORNER = {2'd0, 2'd3, 2'd0, 2'd2, 1'b0, 4'd2};

   assign res = {x_min, x_max, y_min, y_max, bbox_empty, fg_count};

   always #5 CLOCK_50 = ~CLOCK_50;

   bbox_stream_tracker #(
      .WIDTH (W), .HEIGHT (H), .NUM_CH (NC), .DW (DWL), .THRESH (TH)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .reset_n    (reset_n),
      .sof        (sof),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .x_min      (x_min),
      .x_max      (x_max),
      .y_min      (y_min),
      .y_max      (y_max),
      .bbox_empty (bbox_empty),
      .fg_count   (fg_count),
      .frame_done (frame_done),
      .busy       (busy)
   );

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < int'(NB); i++) frame[i] = v;
   endtask

   task automatic pulse_sof(input logic v);
      @(negedge CLOCK_50);
      sof = 1'b1; in_valid = v; in_data = 8'd0;
      @(negedge CLOCK_50);
      sof = 1'b0; in_valid = 1'b0;
   endtask

   // Feeds frame[0..n-1]; after return the last accepted beat has been clocked in.
   task automatic send_beats(input int n, input bit gaps, output int dones, output bit ok);
      int idx = 0;
      int cyc = 0;
      dones = 0;
      while (idx < n && cyc < 2000) begin
         @(negedge CLOCK_50);
         if (frame_done) dones++;
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = frame[idx];
         if (in_valid && in_ready) idx++;
         cyc++;
      end
      @(negedge CLOCK_50);
      in_valid = 1'b0;
      ok = (idx == n);
   endtask

   task automatic run_full_frame(input string name, input bit gaps, input logic [12:0] exp);
      int  d;
      bit  ok;
      send_beats(NB, gaps, d, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL %s timeout: beats not all accepted", name); end
      checks++;
      if (d != 0) begin failures++; $display("FAIL %s early_done: got %0d pulses, want 0", name, d); end
      checks++;
      if (frame_done !== 1'b1) begin failures++; $display("FAIL %s done_latency: got %b want 1", name, frame_done); end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_done: got %b want 1", name, busy); end
      checks++;
      if (res !== exp) begin failures++; $display("FAIL %s result: got %h want %h", name, res, exp); end
      @(negedge CLOCK_50);
      checks++;
      if (frame_done !== 1'b0) begin failures++; $display("FAIL %s done_width: got %b want 0", name, frame_done); end
      checks++;
      if (res !== exp) begin failures++; $display("FAIL %s result_hold: got %h want %h", name, res, exp); end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      checks++;
      if (res !== RES_EMPTY) begin failures++; $display("FAIL reset_outputs: got %h want %h", res, RES_EMPTY); end
      checks++;
      if ({frame_done, busy, in_ready} !== 3'b000) begin
         failures++; $display("FAIL reset_ctrl: got %b want 000", {frame_done, busy, in_ready});
      end
      reset_n = 1'b1;
   endtask

   task automatic test_all_white;
      fill(8'd255);
      pulse_sof(1'b0);
      run_full_frame("all_white", 1'b0, RES_EMPTY);
   endtask

   task automatic test_one_pixel;
      fill(8'd255);
      frame[19] = 8'd249;
      pulse_sof(1'b0);
      run_full_frame("one_px_249", 1'b0, RES_ONE);
      frame[19] = 8'd250;
      pulse_sof(1'b0);
      run_full_frame("one_px_250", 1'b0, RES_EMPTY);
   endtask

   task automatic test_corners;
      fill(8'd255);
      frame[0]  = 8'd0;
      frame[35] = 8'd0;
      pulse_sof(1'b0);
      run_full_frame("corners", 1'b0, RES_CORNER);
   endtask

   task automatic test_backpressure;
      bit rdy_seen = 1'b0;
      // Dark data offered while idle would shift the result if consumed.
      in_valid = 1'b1; in_data = 8'd0;
      repeat (5) begin
         @(negedge CLOCK_50);
         if (in_ready) rdy_seen = 1'b1;
      end
      checks++;
      if (rdy_seen) begin failures++; $display("FAIL idle_ready: got 1 want 0"); end
      fill(8'd255);
      frame[0]  = 8'd0;
      frame[35] = 8'd0;
      pulse_sof(1'b1);
      run_full_frame("backpressure", 1'b1, RES_CORNER);
   endtask

   task automatic test_sof_restart;
      int d;
      bit ok;
      fill(8'd255);
      frame[0] = 8'd10;
      pulse_sof(1'b0);
      send_beats(10, 1'b0, d, ok);
      pulse_sof(1'b0);
      checks++;
      if (d != 0 || frame_done !== 1'b0) begin
         failures++; $display("FAIL restart_no_done: got pulses=%0d done=%b want 0", d, frame_done);
      end
      checks++;
      if (res !== RES_CORNER) begin failures++; $display("FAIL restart_hold: got %h want %h", res, RES_CORNER); end
      checks++;
      if ({busy, in_ready} !== 2'b11) begin failures++; $display("FAIL restart_scan: got %b want 11", {busy, in_ready}); end
      fill(8'd255);
      run_full_frame("after_restart", 1'b0, RES_EMPTY);
   endtask

   task automatic test_reset_mid_scan;
      int d;
      bit ok;
      bit done_seen = 1'b0;
      bit rdy_seen  = 1'b0;
      fill(8'd255);
      frame[0]  = 8'd0;
      frame[35] = 8'd0;
      pulse_sof(1'b0);
      run_full_frame("pre_reset", 1'b0, RES_CORNER);
      pulse_sof(1'b0);
      send_beats(5, 1'b0, d, ok);
      @(negedge CLOCK_50);
      reset_n = 1'b0;
      @(negedge CLOCK_50);
      checks++;
      if (res !== RES_EMPTY) begin failures++; $display("FAIL midreset_outputs: got %h want %h", res, RES_EMPTY); end
      checks++;
      if ({frame_done, busy, in_ready} !== 3'b000) begin
         failures++; $display("FAIL midreset_ctrl: got %b want 000", {frame_done, busy, in_ready});
      end
      reset_n  = 1'b1;
      in_valid = 1'b1; in_data = 8'd0;
      repeat (8) begin
         @(negedge CLOCK_50);
         if (frame_done) done_seen = 1'b1;
         if (in_ready) rdy_seen = 1'b1;
      end
      in_valid = 1'b0;
      checks++;
      if (done_seen || rdy_seen) begin
         failures++; $display("FAIL midreset_idle: got done=%b ready=%b want 0 0", done_seen, rdy_seen);
      end
      pulse_sof(1'b0);
      run_full_frame("post_reset", 1'b0, RES_CORNER);
   endtask

   initial begin
      test_reset();
      test_all_white();
      test_one_pixel();
      test_corners();
      test_backpressure();
      test_sof_restart();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
